// File: rtl/lsu_align_if.sv
// Request/response handshake and data-memory bus for the load/store alignment unit.
// The slave side is the alignment unit; the master side is the core plus data memory.
interface lsu_align_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        dm_we;
    logic [2:0]  dm_i;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               dm_we, dm_i, dm_a, dm_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               dm_we, dm_i, dm_a, dm_wd
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: passes in-word accesses straight to data memory and
// splits word-crossing accesses into byte operations, reassembling loads little-endian.
module lsu_align #(
    parameter int DEPTH_BYTES      = 256,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    lsu_align_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_WAIT,
        S_SPL_ISSUE,
        S_SPL_CAP,
        S_RESP
    } state_t;

    localparam logic [32:0] DEPTH_L = 33'(DEPTH_BYTES);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [2:0]  acc_size;
    logic [32:0] acc_last;
    logic        bad_f3, bad_st, oob, crossing, acc_fault;
    logic [31:0] asm_next, asm_ext;
    logic [7:0]  wbyte;
    logic [31:0] spl_addr;
    logic        dm_we_raw;

    // Accept-time decode of the incoming request
    always_comb begin
        case (bus.req_funct3[1:0])
            2'd0:    acc_size = 3'd1;
            2'd1:    acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
        bad_f3    = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                    (bus.req_funct3 == 3'd7);
        bad_st    = bus.req_we && ((bus.req_funct3 == 3'd4) || (bus.req_funct3 == 3'd5));
        acc_last  = {1'b0, bus.req_addr} + {30'd0, acc_size} - 33'd1;
        oob       = (acc_last >= DEPTH_L);
        crossing  = ((bus.req_funct3[1:0] == 2'd1) && (bus.req_addr[1:0] == 2'd3)) ||
                    ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
        acc_fault = bad_f3 || bad_st || oob || (crossing && !ALLOW_MISALIGNED);
    end

    always_comb begin
        asm_next = asm_q;
        wbyte    = wdata_q[7:0];
        for (int i = 0; i < 4; i++) begin
            if (k_q == 3'(i)) begin
                asm_next[8*i +: 8] = bus.dm_rd[7:0];
                wbyte              = wdata_q[8*i +: 8];
            end
        end
        case (funct3_q)
            3'd1:    asm_ext = {{16{asm_next[15]}}, asm_next[15:0]};
            3'd5:    asm_ext = {16'd0, asm_next[15:0]};
            default: asm_ext = asm_next;
        endcase
        spl_addr = addr_q + {29'd0, k_q};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd2;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            k_q      <= 3'd0;
            n_q      <= 3'd0;
            asm_q    <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            k_q      <= k_d;
            n_q      <= n_d;
            asm_q    <= asm_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        k_d      = k_q;
        n_d      = n_q;
        asm_d    = asm_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    k_d      = 3'd0;
                    n_d      = acc_size;
                    asm_d    = 32'd0;
                    rdata_d  = 32'd0;
                    fault_d  = acc_fault;
                    if (acc_fault)     state_d = S_RESP;
                    else if (crossing) state_d = S_SPL_ISSUE;
                    else               state_d = S_SINGLE;
                end
            end
            S_SINGLE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT: begin
                rdata_d = bus.dm_rd;
                state_d = S_RESP;
            end
            S_SPL_ISSUE: begin
                if (we_q) begin
                    k_d = k_q + 3'd1;
                    if (k_q == n_q - 3'd1) state_d = S_RESP;
                end else begin
                    state_d = S_SPL_CAP;
                end
            end
            S_SPL_CAP: begin
                asm_d = asm_next;
                k_d   = k_q + 3'd1;
                if (k_q == n_q - 3'd1) begin
                    rdata_d = asm_ext;
                    state_d = S_RESP;
                end else begin
                    state_d = S_SPL_ISSUE;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Idle-state bus values double as the reset values of the dm_* outputs
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        dm_we_raw     = 1'b0;
        bus.dm_i      = 3'd2;
        bus.dm_a      = 32'd0;
        bus.dm_wd     = 32'd0;
        case (state_q)
            S_IDLE: bus.req_ready = 1'b1;
            S_SINGLE: begin
                bus.dm_a  = addr_q;
                bus.dm_i  = funct3_q;
                bus.dm_wd = wdata_q;
                dm_we_raw = we_q;
            end
            S_WAIT: begin
                bus.dm_a = addr_q;
                bus.dm_i = funct3_q;
            end
            S_SPL_ISSUE: begin
                bus.dm_a = spl_addr;
                if (we_q) begin
                    bus.dm_i  = 3'd0;
                    bus.dm_wd = {24'd0, wbyte};
                    dm_we_raw = 1'b1;
                end else begin
                    bus.dm_i  = 3'd4;
                end
            end
            S_SPL_CAP: begin
                bus.dm_a = spl_addr;
                bus.dm_i = 3'd4;
            end
            S_RESP:  bus.rsp_valid = 1'b1;
            default: bus.rsp_valid = 1'b0;
        endcase
    end

    // A write must never commit on a reset edge, even mid-split
    assign bus.dm_we     = dm_we_raw & ~RST;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_fault = fault_q & (state_q == S_RESP);

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the core's memory stage and the byte-banked data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Aligned and in-word accesses pass through as a single data-memory operation.
- Word-boundary-crossing accesses are split into sequential byte operations; load bytes are reassembled little-endian and sign/zero-extended.
- Illegal, out-of-range or disallowed misaligned requests are reported as faults.

Parameters:
- DEPTH_BYTES, 256, data-memory size in bytes; power of two.
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses; 0 = fault them.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when valid&ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for B/H.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores/faults.
- rsp_fault  out  1  request rejected; qualifies rsp_valid.
- dm_we  out  1  data-memory write enable.
- dm_i  out  3  data-memory access size code (same encoding as funct3).
- dm_a  out  32  data-memory byte address.
- dm_wd  out  32  data-memory write data.
- dm_rd  in  32  data-memory read data; valid the cycle after address is presented.

Behaviour:
- Clock/reset: one clock CLK; RST is synchronous and active-high.
- Reset values: state IDLE; rsp_valid=0, rsp_fault=0, rsp_rdata=0; dm_we=0, dm_a=0, dm_i=2, dm_wd=0.
- dm_we is gated combinationally by ~RST, so no write commits on a reset edge.
- States: IDLE, SINGLE, WAIT, SPL_ISSUE, SPL_CAP, RESP.
- IDLE: req_ready=1; dm_* at reset values. On accept (edge E0), capture all req_* fields.
- Accept-time decode, first match wins:
  - Fault if funct3 ∈ {3,6,7}, or store with funct3 4/5, or addr+size−1 ≥ DEPTH_BYTES (size 1/2/4; compute with 33-bit add, no wrap). Crossing accesses with ALLOW_MISALIGNED=0 also fault. Fault → RESP.
  - Crossing = halfword with addr[1:0]=3, or word with addr[1:0]≠0. Crossing → SPL_ISSUE with k=0, n=size.
  - Otherwise → SINGLE.
- SINGLE (cycle 1): dm_a=addr, dm_i=funct3, dm_wd=wdata, dm_we=we. Store → RESP; load → WAIT.
- WAIT (cycle 2): hold dm_a/dm_i, dm_we=0; capture dm_rd at end of cycle into rsp_rdata. → RESP.
- Split store, SPL_ISSUE only, one cycle per byte:
  - dm_a=addr+k, dm_i=0, dm_wd[7:0]=wdata byte k, upper bits 0, dm_we=1.
  - k++; after byte n−1 → RESP.
- Split load:
  - SPL_ISSUE: dm_a=addr+k, dm_i=4, dm_we=0.
  - SPL_CAP: hold dm_a/dm_i; capture dm_rd[7:0] into assembly byte k; k++. → SPL_ISSUE, or RESP after byte n−1.
  - Final extension: funct3=1 sign-extends from bit 15, 5 zero-extends, 2 none.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_fault stable; → IDLE.
- req_ready=0 in every state except IDLE.
- Latency from accept edge to rsp_valid cycle:
  - Aligned load 3; aligned store 2; fault 1.
  - Split store n+1; split load 2n+1.
- dm_a is always below DEPTH_BYTES while dm_we=1.
- Reset mid-operation: abandon immediately; bytes already written stay (no rollback); no rsp_valid issued; req_ready=1 in the cycle after the reset edge.
- rsp_rdata retains its value outside rsp_valid; it is cleared only on the next accept or reset.

Test Plan:
- SW 0x10 data 0xDEADBEEF, then LW 0x10 → first rsp_valid 2 cycles after accept; LW rsp_rdata=0xDEADBEEF, 3 cycles after accept; rsp_fault=0.
- Byte 0x11 = 0x80: LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LH 0x10 with bytes 0x10/0x11 = 0x34/0x80 → 0xFFFF8034; LHU → 0x00008034.
- SW 0x21 data 0x11223344 → dm_we pulses 4 consecutive cycles, dm_a 0x21..0x24, dm_wd[7:0] 44,33,22,11, dm_i=0; rsp 5 cycles after accept. LW 0x21 → 0x11223344, rsp 9 cycles after accept.
- Bytes 0x23=0x34, 0x24=0xF2: LH 0x23 → 0xFFFFF234, LHU 0x23 → 0x0000F234. With ALLOW_MISALIGNED=0: LH 0x23 → rsp_fault=1, rdata 0, dm_we never asserted.
- Faults: funct3=3; SH funct3=5; SW 0xFE with DEPTH_BYTES=256 → rsp_valid+rsp_fault 1 cycle after accept, no dm_we.
- RST asserted after 2 bytes of split SW 0x21 → bytes 0x21/0x22 written, 0x23/0x24 unchanged, no rsp_valid, req_ready=1 next cycle; next aligned LW completes normally.
